// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// Requester-side APB engine. Turns a single-outstanding req/gnt + rvalid
// core interface into APB SETUP/ACCESS transfers, one transfer in flight.
//
// Optional feature (macro APB_MASTER_TIMEOUT_EN): an ACCESS-phase timeout
// that completes a transfer with err_o=1 after TIMEOUT_CYCLES cycles of
// pready_i low. Without the macro, ACCESS waits indefinitely.
//
// State table:
//   IDLE   | gnt_o high, waiting for req_i; response strobe lands here
//   SETUP  | psel_o=1, penable_o=0, one cycle
//   ACCESS | psel_o=1, penable_o=1, until pready_i (or timeout)
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   req_i, we_i, addr_i, wdata_i   core request
//   gnt_o                          request accepted this cycle (comb)
//   rvalid_o, rdata_o, err_o       registered response
//   psel_o, penable_o, pwrite_o,
//   paddr_o, pwdata_o              registered APB request
//   prdata_i, pready_i, pslverr_i  APB completion
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      psel_d, penable_d, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_d, rdata_d;
    logic                      rvalid_d, err_d;
    logic                      tmo_hit;

    assign gnt_o = (state_q == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Abort fires on the cycle whose pready_i-low would bring the count
    // to TIMEOUT_CYCLES, i.e. after exactly TIMEOUT_CYCLES low cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == SETUP) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ACCESS) && !pready_i) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == ACCESS) && !pready_i && (tmo_cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    // Every output is registered; the comb block computes their next values.
    // Request fields hold their value by default so they stay stable from
    // SETUP through the last ACCESS cycle and keep it in IDLE.
    always_comb begin
        state_d   = state_q;
        psel_d    = psel_o;
        penable_d = penable_o;
        pwrite_d  = pwrite_o;
        paddr_d   = paddr_o;
        pwdata_d  = pwdata_o;
        rdata_d   = rdata_o;
        err_d     = err_o;
        rvalid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    paddr_d  = addr_i;
                    pwdata_d = wdata_i;
                    pwrite_d = we_i;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready_i wins over a timeout landing in the same cycle.
                if (pready_i) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    err_d     = pslverr_i;
                    rdata_d   = (!pwrite_o && !pslverr_i) ? prdata_i : '0;
                    state_d   = IDLE;
                end else if (tmo_hit) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
            rvalid_o  <= 1'b0;
        end else begin
            state_q   <= state_d;
            psel_o    <= psel_d;
            penable_o <= penable_d;
            pwrite_o  <= pwrite_d;
            paddr_o   <= paddr_d;
            pwdata_o  <= pwdata_d;
            rdata_o   <= rdata_d;
            err_o     <= err_d;
            rvalid_o  <= rvalid_d;
        end
    end

endmodule
